// File: rtl/pwm_fade_seq.sv
// pwm_fade_seq: command sequencer driving the PWM d/sel write port with single writes and period-paced CMP fades.
// Build option SYNC_WRITE_EN defers CMP writes to the cycle after a PWM period end.
module pwm_fade_seq #(
  parameter int W = 16,
  parameter int PERIODS_PER_STEP = 1
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         i_cmd_valid,
  output logic         o_cmd_ready,
  input  logic [1:0]   i_cmd_op,
  input  logic [W-1:0] i_cmd_data,
  input  logic [W-1:0] i_cmd_step,
  input  logic         i_abort,
  input  logic [W-1:0] i_pwm_cnt,
  input  logic [W-1:0] i_pwm_top,
  output logic [1:0]   o_sel,
  output logic [W-1:0] o_d,
  output logic [W-1:0] o_cmp_shadow,
  output logic         o_busy,
  output logic         o_done
);
`ifdef SYNC_WRITE_EN
  localparam bit DEFER_CMP = 1'b1;
`else
  localparam bit DEFER_CMP = 1'b0;
`endif
  localparam int PCW = PERIODS_PER_STEP > 1 ? $clog2(PERIODS_PER_STEP) : 1;
  localparam logic [PCW-1:0] PC_LAST = PCW'(PERIODS_PER_STEP - 1);
  typedef enum logic [1:0] {IDLE, WRITE, FADE_WAIT, FADE_WR} state_t;
  state_t         r_state;
  logic [W-1:0]   r_tgt, r_step, r_d, r_shadow;
  logic [1:0]     r_sel;
  logic           r_done, r_pend;
  logic [PCW-1:0] r_pc;
  logic           w_pe, w_accept, w_up, w_defer;
  logic [W-1:0]   w_step, w_nxt;
  logic [W:0]     w_sum, w_dif;
  assign o_cmd_ready  = (r_state == IDLE) && nrst;
  assign o_busy       = r_state != IDLE;
  assign o_sel        = r_sel;
  assign o_d          = r_d;
  assign o_cmp_shadow = r_shadow;
  assign o_done       = r_done;
  assign w_pe     = i_pwm_cnt >= i_pwm_top;
  assign w_accept = i_cmd_valid && o_cmd_ready;
  assign w_defer  = DEFER_CMP && (i_cmd_op == 2'b01);
  assign w_step   = (i_cmd_step == '0) ? W'(1) : i_cmd_step;
  // Step arithmetic is one bit wider so a clamp to target can never wrap.
  assign w_up  = r_tgt > r_shadow;
  assign w_sum = {1'b0, r_shadow} + {1'b0, r_step};
  assign w_dif = {1'b0, r_shadow} - {1'b0, r_step};
  assign w_nxt = w_up ? ((w_sum > {1'b0, r_tgt}) ? r_tgt : w_sum[W-1:0])
                      : ((w_dif[W] || (w_dif[W-1:0] < r_tgt)) ? r_tgt : w_dif[W-1:0]);
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state  <= IDLE;
      r_sel    <= 2'b00;
      r_d      <= '0;
      r_shadow <= '0;
      r_done   <= 1'b0;
      r_pend   <= 1'b0;
      r_pc     <= '0;
      r_tgt    <= '0;
      r_step   <= '0;
    end else begin
      r_sel  <= 2'b00;
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_tgt <= i_cmd_data;
          if (i_cmd_op == 2'b00) begin
            r_step <= w_step;
            r_pc   <= '0;
            if (i_cmd_data == r_shadow) r_done <= 1'b1;
            else r_state <= FADE_WAIT;
          end else begin
            r_state <= WRITE;
            r_pend  <= w_defer;
            if (!w_defer) begin
              r_sel <= i_cmd_op;
              r_d   <= i_cmd_data;
              if (i_cmd_op == 2'b01) r_shadow <= i_cmd_data;
            end
          end
        end
        WRITE: if (!r_pend) r_state <= IDLE;
        else if (i_abort) begin
          r_pend  <= 1'b0;
          r_state <= IDLE;
        end else if (w_pe) begin
          r_pend   <= 1'b0;
          r_sel    <= 2'b01;
          r_d      <= r_tgt;
          r_shadow <= r_tgt;
        end
        FADE_WAIT: if (i_abort) r_state <= IDLE;
        else if (w_pe) begin
          if (r_pc == PC_LAST) begin
            r_pc     <= '0;
            r_sel    <= 2'b01;
            r_d      <= w_nxt;
            r_shadow <= w_nxt;
            r_done   <= w_nxt == r_tgt;
            r_state  <= FADE_WR;
          end else r_pc <= r_pc + 1'b1;
        end
        FADE_WR: r_state <= (i_abort || r_shadow == r_tgt) ? IDLE : FADE_WAIT;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
